// File: rtl/cola_vend_fsm.sv
// Coin-operated cola vending controller: price 2.5 units, accepts 0.5/1.0 coins, one-hot credit FSM.
// Optional dispensed-cola counter output enabled by defining COLA_CNT_EN.
module cola_vend_fsm #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             pi_money_half,
  input  logic             pi_money_one,
  output logic             po_cola,
`ifdef COLA_CNT_EN
  output logic             po_money,
  output logic [CNT_W-1:0] po_cola_cnt
`else
  output logic             po_money
`endif
);

  localparam int unsigned STATE_W = 5;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 5'b00001,
    HALF     = 5'b00010,
    ONE      = 5'b00100,
    ONE_HALF = 5'b01000,
    TWO      = 5'b10000
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] pi_money;
  logic       half;
  logic       one;
  logic       cola_nxt;
  logic       money_nxt;

  // Illegal code 2'b11 decodes to neither coin, so it behaves like no coin.
  assign pi_money = {pi_money_one, pi_money_half};
  assign half     = (pi_money == 2'b01);
  assign one      = (pi_money == 2'b10);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next credit state and the pulses generated by the coin sampled this cycle.
  always_comb begin
    state_nxt = state;
    cola_nxt  = 1'b0;
    money_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (half)     state_nxt = HALF;
        else if (one) state_nxt = ONE;
      end
      HALF: begin
        if (half)     state_nxt = ONE;
        else if (one) state_nxt = ONE_HALF;
      end
      ONE: begin
        if (half)     state_nxt = ONE_HALF;
        else if (one) state_nxt = TWO;
      end
      ONE_HALF: begin
        if (half) begin
          state_nxt = TWO;
        end else if (one) begin
          state_nxt = IDLE;
          cola_nxt  = 1'b1;
        end
      end
      TWO: begin
        if (half || one) begin
          state_nxt = IDLE;
          cola_nxt  = 1'b1;
          money_nxt = one;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      po_cola  <= 1'b0;
      po_money <= 1'b0;
    end else begin
      po_cola  <= cola_nxt;
      po_money <= money_nxt;
    end
  end

`ifdef COLA_CNT_EN
  // Counts in step with po_cola; wraps naturally at all-ones.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      po_cola_cnt <= '0;
    end else if (cola_nxt) begin
      po_cola_cnt <= po_cola_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_cola_vend_fsm.sv
// Directed and scoreboarded bench for cola_vend_fsm; covers COLA_CNT_EN counter when defined.
module tb_cola_vend_fsm;

  localparam int unsigned CNT_W = 8;

  logic sys_clk;
  logic sys_rst_n;
  logic pi_money_half;
  logic pi_money_one;
  logic po_cola;
  logic po_money;
`ifdef COLA_CNT_EN
  logic [CNT_W-1:0] po_cola_cnt;
  logic [CNT_W-1:0] exp_cnt;
`endif

  int vectors;
  int miscompares;

  cola_vend_fsm #(.CNT_W(CNT_W)) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .pi_money_half (pi_money_half),
    .pi_money_one  (pi_money_one),
    .po_cola       (po_cola),
`ifdef COLA_CNT_EN
    .po_money      (po_money),
    .po_cola_cnt   (po_cola_cnt)
`else
    .po_money      (po_money)
`endif
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [4:0] es, input logic ec, input logic em);
    logic [4:0] obs;
    obs = dut.state;
    vectors++;
    assert (obs === es) else begin
      miscompares++;
      $error("FAIL %s.state observed=%b expected=%b", tag, obs, es);
    end
    check_bit({tag, ".cola"}, po_cola, ec);
    check_bit({tag, ".money"}, po_money, em);
`ifdef COLA_CNT_EN
    vectors++;
    assert (po_cola_cnt === exp_cnt) else begin
      miscompares++;
      $error("FAIL %s.cnt observed=%0d expected=%0d", tag, po_cola_cnt, exp_cnt);
    end
`endif
  endtask

  // Drive one coin code at the falling edge, check one settle time after the rising edge.
  task automatic apply(input string tag, input logic h, input logic o,
                       input logic [4:0] es, input logic ec, input logic em);
    @(negedge sys_clk);
    pi_money_half = h;
    pi_money_one  = o;
    @(posedge sys_clk);
    #1;
`ifdef COLA_CNT_EN
    if (ec) exp_cnt = exp_cnt + CNT_W'(1);
`endif
    check_all(tag, es, ec, em);
  endtask

  initial begin
    int credit;
    int nc;
    logic h;
    logic ec;
    logic em;
    vectors       = 0;
    miscompares   = 0;
    sys_rst_n     = 1'b0;
    pi_money_half = 1'b0;
    pi_money_one  = 1'b0;
`ifdef COLA_CNT_EN
    exp_cnt = '0;
`endif

    // Reset held 20 ns while coins toggle
    #2 pi_money_half = 1'b1;
    #5 pi_money_one  = 1'b1;
    #5 pi_money_half = 1'b0;
    #8;
    check_all("reset", 5'b00001, 1'b0, 1'b0);
    @(negedge sys_clk);
    pi_money_half = 1'b0;
    pi_money_one  = 1'b0;
    sys_rst_n     = 1'b1;

    // Five halves
    apply("h5_1", 1, 0, 5'b00010, 0, 0);
    apply("h5_2", 1, 0, 5'b00100, 0, 0);
    apply("h5_3", 1, 0, 5'b01000, 0, 0);
    apply("h5_4", 1, 0, 5'b10000, 0, 0);
    apply("h5_5", 1, 0, 5'b00001, 1, 0);
    apply("h5_idle", 0, 0, 5'b00001, 0, 0);

    // Half, one, one
    apply("hoo_1", 1, 0, 5'b00010, 0, 0);
    apply("hoo_2", 0, 1, 5'b01000, 0, 0);
    apply("hoo_3", 0, 1, 5'b00001, 1, 0);

    // One x3 with change, then back-to-back new transaction
    apply("ooo_1", 0, 1, 5'b00100, 0, 0);
    apply("ooo_2", 0, 1, 5'b10000, 0, 0);
    apply("ooo_3", 0, 1, 5'b00001, 1, 1);
    apply("b2b_1", 1, 0, 5'b00010, 0, 0);
    apply("b2b_2", 0, 1, 5'b01000, 0, 0);

    // Idle and illegal codes mid-transaction hold state
    apply("hold_idle", 0, 0, 5'b01000, 0, 0);
    apply("hold_ill", 1, 1, 5'b01000, 0, 0);
    apply("hold_ill2", 1, 1, 5'b01000, 0, 0);
    apply("b2b_3", 1, 0, 5'b10000, 0, 0);
    apply("hold_two", 1, 1, 5'b10000, 0, 0);
    apply("b2b_4", 1, 0, 5'b00001, 1, 0);

    // Async reset mid-transaction in ONE_HALF
    apply("ar_1", 0, 1, 5'b00100, 0, 0);
    apply("ar_2", 1, 0, 5'b01000, 0, 0);
    @(negedge sys_clk);
    pi_money_half = 1'b0;
    pi_money_one  = 1'b0;
    sys_rst_n     = 1'b0;
    #1;
`ifdef COLA_CNT_EN
    exp_cnt = '0;
`endif
    check_all("ar_async", 5'b00001, 0, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    apply("ar_after", 0, 1, 5'b00100, 0, 0);
    apply("ar_after2", 0, 1, 5'b10000, 0, 0);
    apply("ar_after3", 1, 0, 5'b00001, 1, 0);

    // Random single coins against a credit model (units of 0.5)
    credit = 0;
    for (int i = 0; i < 1000; i++) begin
      h  = 1'($urandom_range(0, 1));
      nc = credit + (h ? 1 : 2);
      ec = 1'b0;
      em = 1'b0;
      if (nc >= 5) begin
        ec = 1'b1;
        em = (nc == 6);
        nc = 0;
      end
      credit = nc;
      apply("rand", h, ~h, 5'(1 << credit), ec, em);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
